// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a scanned, active-high 7-segment display bus.
// Optional macro SEG7_DP_CAPTURE_EN: capture the decimal point of each digit into oDP.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [7:0]  iAN,
  input  logic [7:0]  iSEG,
  input  logic        iCLR_ERR,
  output logic [31:0] oHEX,
  output logic [7:0]  oVALID,
  output logic [7:0]  oDP,
  output logic        oFRAME,
  output logic        oERR
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYC);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  count_reg, count_next;
  logic [15:0] s_reg, p_reg;
  logic [7:0]  seg_in;
  logic [7:0]  s_an;
  logic [6:0]  s_seg;
  logic        s_onehot, s_same, capture;
  logic [3:0]  dec_nib;
  logic        dec_hit, dec_err;
  logic [7:0]  mask_reg, mask_cap;
  logic        frame_reg, err_reg;

`ifdef SEG7_DP_CAPTURE_EN
  assign seg_in = iSEG;
`else
  // dp is forced low so it can never disturb the stability compare
  logic unused_dp;
  assign unused_dp = iSEG[7];
  assign seg_in    = {1'b0, iSEG[6:0]};
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s_reg <= '0;
      p_reg <= '0;
    end else begin
      s_reg <= {iAN, seg_in};
      p_reg <= s_reg;
    end
  end

  assign s_an     = s_reg[15:8];
  assign s_seg    = s_reg[6:0];
  assign s_onehot = (s_an != 8'h00) && ((s_an & (s_an - 8'd1)) == 8'h00);
  assign s_same   = (s_reg == p_reg);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s_onehot) begin
          state_next = SETTLE;
          count_next = 8'd1;
        end
      end
      SETTLE: begin
        if (!s_same || !s_onehot) begin
          state_next = s_onehot ? SETTLE : IDLE;
          count_next = s_onehot ? 8'd1 : 8'd0;
        end else if (count_reg + 8'd1 >= STABLE_LIM) begin
          capture    = 1'b1;
          state_next = HOLD;
          count_next = count_reg + 8'd1;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      HOLD: begin
        if (!s_same) begin
          state_next = s_onehot ? SETTLE : IDLE;
          count_next = s_onehot ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = 8'd0;
      end
    endcase
  end

  always_comb begin
    dec_hit = 1'b1;
    dec_nib = 4'h0;
    case (s_seg)
      7'h7E: dec_nib = 4'h0;
      7'h30: dec_nib = 4'h1;
      7'h6D: dec_nib = 4'h2;
      7'h79: dec_nib = 4'h3;
      7'h33: dec_nib = 4'h4;
      7'h5B: dec_nib = 4'h5;
      7'h5F: dec_nib = 4'h6;
      7'h70: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h7B: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h1F: dec_nib = 4'hB;
      7'h4E: dec_nib = 4'hC;
      7'h3D: dec_nib = 4'hD;
      7'h4F: dec_nib = 4'hE;
      7'h47: dec_nib = 4'hF;
      default: dec_hit = 1'b0;
    endcase
  end

  // a blank digit is a legitimate "off" state, not a decode error
  assign dec_err = !dec_hit && (s_seg != 7'h00);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      logic [3:0] nib_reg;
      logic       valid_reg;

      always_ff @(posedge iCLK) begin
        if (iRST) begin
          nib_reg   <= '0;
          valid_reg <= 1'b0;
        end else if (capture && s_an[gi]) begin
          if (dec_hit) nib_reg <= dec_nib;
          valid_reg <= dec_hit;
        end
      end

      assign oHEX[4*gi +: 4] = nib_reg;
      assign oVALID[gi]      = valid_reg;

`ifdef SEG7_DP_CAPTURE_EN
      logic dp_reg;
      always_ff @(posedge iCLK) begin
        if (iRST) dp_reg <= 1'b0;
        else if (capture && s_an[gi]) dp_reg <= s_reg[7];
      end
      assign oDP[gi] = dp_reg;
`else
      assign oDP[gi] = 1'b0;
`endif
    end
  endgenerate

  assign mask_cap = mask_reg | s_an;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      mask_reg  <= '0;
      frame_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      frame_reg <= 1'b0;
      if (capture) begin
        if (mask_cap == 8'hFF) begin
          mask_reg  <= 8'h00;
          frame_reg <= 1'b1;
        end else begin
          mask_reg <= mask_cap;
        end
      end
      // a fresh error wins over a simultaneous clear
      if (capture && dec_err) err_reg <= 1'b1;
      else if (iCLR_ERR)      err_reg <= 1'b0;
    end
  end

  assign oFRAME = frame_reg;
  assign oERR   = err_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: constant vector table, hand-written corner sequences,
// and randomized scanning checked every cycle against a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        iRST, iCLR_ERR;
  logic [7:0]  iAN, iSEG;
  logic [31:0] oHEX;
  logic [7:0]  oVALID, oDP;
  logic        oFRAME, oERR;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYC(SC)) dut (
    .iCLK(clk), .iRST(iRST), .iAN(iAN), .iSEG(iSEG), .iCLR_ERR(iCLR_ERR),
    .oHEX(oHEX), .oVALID(oVALID), .oDP(oDP), .oFRAME(oFRAME), .oERR(oERR)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int frame_cnt = 0;

  // reference model state: outputs plus the latest sample and how long it has repeated
  logic [31:0] m_hex;
  logic [7:0]  m_valid, m_dp, m_mask;
  logic        m_frame, m_err;
  logic [15:0] last_val;
  int          run_len;
  logic [6:0]  pat [16];

  typedef struct {
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        clr;
    int          cyc;
    logic [31:0] hex;
    logic [7:0]  valid;
    logic        err;
    int          frames;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hex = '0; m_valid = '0; m_dp = '0; m_mask = '0; m_frame = 1'b0; m_err = 1'b0;
    last_val = '0; run_len = 1;
  endtask

  // a digit is captured once its one-hot sample has repeated exactly SC times in a row
  task automatic model_edge(input logic [7:0] an, input logic [7:0] seg, input logic clr, input logic rst);
    logic [7:0]  lan;
    logic [7:0]  lseg;
    logic [15:0] v;
    logic        found, cap_err;
    logic [3:0]  nib;
    int          d;
    if (rst) begin
      model_reset();
      return;
    end
    lan = last_val[15:8];
    lseg = last_val[7:0];
    m_frame = 1'b0;
    cap_err = 1'b0;
    if ($countones(lan) == 1 && run_len == SC) begin
      d = 0;
      for (int i = 0; i < 8; i++) if (lan[i]) d = i;
      found = 1'b0;
      nib = 4'h0;
      for (int k = 0; k < 16; k++) if (pat[k] == lseg[6:0]) begin found = 1'b1; nib = 4'(k); end
      if (found) m_hex[4*d +: 4] = nib;
      m_valid[d] = found;
      if (!found && lseg[6:0] != 7'h00) cap_err = 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
      m_dp[d] = lseg[7];
`endif
      m_mask[d] = 1'b1;
      if (m_mask == 8'hFF) begin
        m_frame = 1'b1;
        m_mask = 8'h00;
      end
    end
    if (cap_err) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
    v = {an, seg};
`else
    v = {an, 1'b0, seg[6:0]};
`endif
    if (v == last_val) begin
      if (run_len < 1000) run_len++;
    end else begin
      last_val = v;
      run_len = 1;
    end
  endtask

  // drive at the falling edge, advance one rising edge, compare at the next falling edge
  task automatic step(input logic [7:0] an, input logic [7:0] seg, input logic clr, input logic rst);
    iAN = an; iSEG = seg; iCLR_ERR = clr; iRST = rst;
    @(posedge clk);
    model_edge(an, seg, clr, rst);
    @(negedge clk);
    if (oFRAME) frame_cnt++;
    chk("model_hex", oHEX, m_hex);
    chk("model_valid", {24'h0, oVALID}, {24'h0, m_valid});
    chk("model_dp", {24'h0, oDP}, {24'h0, m_dp});
    chk("model_frame", {31'h0, oFRAME}, {31'h0, m_frame});
    chk("model_err", {31'h0, oERR}, {31'h0, m_err});
  endtask

  task automatic add(input logic [7:0] an, input logic [7:0] seg, input logic clr, input int cyc,
                     input logic [31:0] hex, input logic [7:0] valid, input logic err, input int frames);
    vec_t v;
    v.an = an; v.seg = seg; v.clr = clr; v.cyc = cyc;
    v.hex = hex; v.valid = valid; v.err = err; v.frames = frames;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] r_an, r_seg;
    int r, len;
    pat = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    model_reset();
    iRST = 1'b1; iAN = '0; iSEG = '0; iCLR_ERR = 1'b0;
    @(negedge clk);
    step(8'h00, 8'h00, 1'b0, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b1);
    chk("rst_hex", oHEX, 32'h0);
    chk("rst_valid", {24'h0, oVALID}, 32'h0);
    chk("rst_frame_err", {30'h0, oFRAME, oERR}, 32'h0);
    $display("reset done");

    // capture latency: nothing after SC cycles, digit 0 = 2 after SC+1
    for (int c = 0; c < SC; c++) step(8'h01, 8'h6D, 1'b0, 1'b0);
    chk("lat_early_valid", {24'h0, oVALID}, 32'h0);
    step(8'h01, 8'h6D, 1'b0, 1'b0);
    chk("lat_valid", {24'h0, oVALID}, 32'h1);
    chk("lat_hex", {28'h0, oHEX[3:0]}, 32'h2);
    $display("latency sequence hex=%h valid=%h", oHEX, oVALID);

    add(8'h01, 8'h7E, 1'b0, 8,  32'h0000_0000, 8'h01, 1'b0, 0);
    add(8'h02, 8'h30, 1'b0, 8,  32'h0000_0010, 8'h03, 1'b0, 0);
    add(8'h04, 8'h6D, 1'b0, 8,  32'h0000_0210, 8'h07, 1'b0, 0);
    add(8'h08, 8'h79, 1'b0, 8,  32'h0000_3210, 8'h0F, 1'b0, 0);
    add(8'h10, 8'h33, 1'b0, 8,  32'h0004_3210, 8'h1F, 1'b0, 0);
    add(8'h20, 8'h5B, 1'b0, 8,  32'h0054_3210, 8'h3F, 1'b0, 0);
    add(8'h40, 8'h5F, 1'b0, 8,  32'h0654_3210, 8'h7F, 1'b0, 0);
    add(8'h80, 8'h70, 1'b0, 8,  32'h7654_3210, 8'hFF, 1'b0, 1);
    add(8'h04, 8'h55, 1'b0, 8,  32'h7654_3210, 8'hFB, 1'b1, 1);
    add(8'h04, 8'h55, 1'b1, 1,  32'h7654_3210, 8'hFB, 1'b0, 1);
    add(8'h10, 8'h00, 1'b0, 8,  32'h7654_3210, 8'hEB, 1'b0, 1);
    add(8'h03, 8'h7E, 1'b0, 20, 32'h7654_3210, 8'hEB, 1'b0, 1);
    add(8'h00, 8'h7E, 1'b0, 20, 32'h7654_3210, 8'hEB, 1'b0, 1);

    frame_cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].cyc; c++) step(tbl[i].an, tbl[i].seg, tbl[i].clr, 1'b0);
      chk("vec_hex", oHEX, tbl[i].hex);
      chk("vec_valid", {24'h0, oVALID}, {24'h0, tbl[i].valid});
      chk("vec_err", {31'h0, oERR}, {31'h0, tbl[i].err});
      chk("vec_frames", 32'(frame_cnt), 32'(tbl[i].frames));
      $display("vec %0d an=%h seg=%h clr=%b hex=%h valid=%h err=%b frames=%0d",
               i, tbl[i].an, tbl[i].seg, tbl[i].clr, oHEX, oVALID, oERR, frame_cnt);
    end

    // segments toggling every 2 cycles never settle
    for (int c = 0; c < 12; c++) step(8'h01, ((c / 2) % 2) ? 8'h30 : 8'h7E, 1'b0, 1'b0);
    chk("toggle_hex", oHEX, 32'h7654_3210);
    chk("toggle_valid", {24'h0, oVALID}, 32'hEB);
    $display("toggle sequence hex=%h valid=%h", oHEX, oVALID);

    // clear arriving in the same cycle as a new error
    for (int c = 0; c < SC; c++) step(8'h08, 8'h55, 1'b0, 1'b0);
    chk("clr_pre_err", {31'h0, oERR}, 32'h0);
    chk("clr_pre_valid", {24'h0, oVALID}, 32'hEB);
    step(8'h08, 8'h55, 1'b1, 1'b0);
    chk("clr_vs_err", {31'h0, oERR}, 32'h1);
    chk("clr_vs_err_valid", {24'h0, oVALID}, 32'hE3);
    $display("clear-vs-error sequence err=%b valid=%h", oERR, oVALID);

    // reset in the middle of a settle window
    for (int c = 0; c < SC - 1; c++) step(8'h20, 8'h5B, 1'b0, 1'b0);
    step(8'h20, 8'h5B, 1'b0, 1'b1);
    chk("midrst_hex", oHEX, 32'h0);
    chk("midrst_flags", {22'h0, oVALID, oFRAME, oERR}, 32'h0);
    for (int c = 0; c < 6; c++) step(8'h00, 8'h00, 1'b0, 1'b0);
    chk("midrst_after_hex", oHEX, 32'h0);
    chk("midrst_after_valid", {24'h0, oVALID}, 32'h0);
    $display("mid-settle reset sequence hex=%h valid=%h", oHEX, oVALID);

    // digit 7 showing 8 with decimal point lit
    for (int c = 0; c < 8; c++) step(8'h80, 8'hFF, 1'b0, 1'b0);
    chk("dp_hex", oHEX, 32'h8000_0000);
    chk("dp_valid", {24'h0, oVALID}, 32'h80);
`ifdef SEG7_DP_CAPTURE_EN
    chk("dp_flag", {24'h0, oDP}, 32'h80);
`else
    chk("dp_flag", {24'h0, oDP}, 32'h00);
`endif
    $display("dp sequence hex=%h dp=%h", oHEX, oDP);

    for (int b = 0; b < 500; b++) begin
      r = $urandom_range(0, 99);
      if (r < 75)      r_an = 8'h01 << $urandom_range(0, 7);
      else if (r < 85) r_an = 8'h00;
      else             r_an = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 65)      r_seg = {1'($urandom), pat[$urandom_range(0, 15)]};
      else if (r < 80) r_seg = {1'($urandom), 7'h00};
      else             r_seg = 8'($urandom);
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++)
        step(r_an, r_seg, ($urandom_range(0, 15) == 0), ($urandom_range(0, 399) == 0));
      $display("rand %0d an=%h seg=%h len=%0d hex=%h valid=%h err=%b", b, r_an, r_seg, len, oHEX, oVALID, oERR);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL provide parameter STABLE_CYC, default 4, meaning consecutive identical samples required before capture (legal range 2..255).
REQ-002 SHALL provide port iCLK, input, 1, the single clock; all logic rising-edge.
REQ-003 SHALL provide port iRST, input, 1, synchronous active-high reset.
REQ-004 SHALL provide port iAN, input, 8, digit enables, active-high, expected one-hot; bit n = digit n.
REQ-005 SHALL provide port iSEG, input, 8, segment drive, active-high; [6:0] = {a,b,c,d,e,f,g}, [7] = dp.
REQ-006 SHALL provide port iCLR_ERR, input, 1, single-cycle clear of oERR.
REQ-007 SHALL provide port oHEX, output, 32, decoded nibbles; digit n at [4n+3:4n].
REQ-008 SHALL provide port oVALID, output, 8, per-digit flag: last capture decoded to a hex value.
REQ-009 SHALL provide port oDP, output, 8, per-digit captured decimal point.
REQ-010 SHALL provide port oFRAME, output, 1, one-cycle pulse when all 8 digits have been captured.
REQ-011 SHALL provide port oERR, output, 1, sticky flag: an unrecognised non-blank pattern was captured.

Function
REQ-012 SHALL register {iAN,iSEG} into sample register S every cycle; all decisions use S and the previous sample P (S from the prior cycle).
REQ-013 SHALL implement states IDLE, SETTLE, HOLD.
REQ-014 IDLE: if S.an is one-hot -> SETTLE with count=1; otherwise stay.
REQ-015 SETTLE: if S==P, count increments; if S!=P, count=1 and stay in SETTLE (or IDLE if S.an not one-hot).
REQ-016 SETTLE: when count reaches STABLE_CYC, capture in that same cycle and go to HOLD.
REQ-017 HOLD: no further capture; on S!=P go to SETTLE with count=1, or to IDLE if S.an not one-hot.
REQ-018 Capture latency SHALL be STABLE_CYC+1 cycles from first cycle iAN/iSEG present stable to oHEX/oVALID update.
REQ-019 Decode table (segments [6:0] -> nibble): 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F.
REQ-020 On capture of a table pattern: nibble written, oVALID[n]=1.
REQ-021 On capture of blank (segments 00): nibble unchanged, oVALID[n]=0, no error.
REQ-022 On capture of any other pattern: nibble unchanged, oVALID[n]=0, oERR set next edge.
REQ-023 oERR SHALL clear on iCLR_ERR; a simultaneous new error takes priority (oERR stays 1).
REQ-024 A seen-mask SHALL set bit n on each capture of digit n (valid, blank or error).
REQ-025 When a capture makes the mask 8'hFF, oFRAME SHALL pulse the following cycle and the mask SHALL clear to 0 in that same cycle.
REQ-026 Recapture of an already-seen digit SHALL not pulse oFRAME.
REQ-027 Non-one-hot iAN (zero or multiple bits) SHALL never cause a capture.

Reset
REQ-028 iRST SHALL set state IDLE, count 0, S and P 0, mask 0, oHEX 0, oVALID 0, oDP 0, oFRAME 0, oERR 0.
REQ-029 Reset asserted mid-SETTLE SHALL abort the pending capture; no output changes other than to reset values.

Configuration
REQ-030 With macro SEG7_DP_CAPTURE_EN defined, oDP[n] SHALL load iSEG[7] on each capture of digit n.
REQ-031 Without SEG7_DP_CAPTURE_EN, oDP SHALL be constant 0, iSEG[7] ignored, and S/P compare SHALL exclude bit 7.

Verification
REQ-032 Hold iAN=01, iSEG=6D for 10 cycles -> oHEX[3:0]=2, oVALID[0]=1 exactly STABLE_CYC+1 cycles after first stable cycle.
REQ-033 Scan 8 digits showing 0..7, each held 8 cycles -> oHEX=32'h76543210, oVALID=FF, one oFRAME pulse after digit 7 capture, none earlier.
REQ-034 iAN=01, iSEG toggles 7E/30 every 2 cycles (STABLE_CYC=4) -> no capture, oHEX unchanged.
REQ-035 iAN=04, iSEG=55 stable 8 cycles -> oVALID[2]=0, oERR=1; iCLR_ERR pulse -> oERR=0; iCLR_ERR same cycle as new error -> oERR stays 1.
REQ-036 iAN=03 or 00 with iSEG=7E for 20 cycles -> no capture, mask unchanged; iRST during SETTLE -> all outputs 0, no capture.
REQ-037 With SEG7_DP_CAPTURE_EN, iAN=80, iSEG=FF stable -> oHEX[31:28]=8, oDP[7]=1; without macro oDP=0.
